// File: rtl/joystick_scanner_if.sv
// DRP bus between joystick_scanner (master) and xadc_wiz_0 (slave).
// Handshake: the master raises drp_den for exactly one cycle, with drp_daddr
// valid in that cycle. The slave later answers with a one-cycle drp_drdy;
// drp_do is valid only in that cycle. The master issues no new drp_den until
// it has seen the drp_drdy for the previous read (or has given up on it).
interface joystick_scanner_if;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic [15:0] drp_do;
  logic        drp_drdy;

  modport master (output drp_daddr, output drp_den, input drp_do, input drp_drdy);
  modport slave  (input drp_daddr, input drp_den, output drp_do, output drp_drdy);
endinterface

// File: rtl/joystick_scanner.sv
// joystick_scanner: sweeps NUM_CH XADC aux channels over DRP on each
// sample_req pulse, classifies each 12-bit sample as LOW/CENTRE/HIGH with
// hysteresis and a consecutive-sample filter, and drives direction flags.
// Optional: define JOYSCAN_TIMEOUT_EN to bound the wait for drp_drdy to
// TIMEOUT cycles; a timed-out channel keeps its old state and timeout_err
// latches until reset.
module joystick_scanner #(
  parameter int                  NUM_CH   = 4,
  parameter logic [NUM_CH*7-1:0] CH_ADDR  = {7'h1F, 7'h1E, 7'h17, 7'h16},
  parameter logic [11:0]         LOW_TH   = 12'h400,
  parameter logic [11:0]         HIGH_TH  = 12'hC00,
  parameter logic [11:0]         HYST     = 12'h080,
  parameter int                  FILT_CNT = 2,
  parameter int                  TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_req,
  joystick_scanner_if.master    drp,
  output logic [NUM_CH-1:0]     dir_lo,
  output logic [NUM_CH-1:0]     dir_hi,
  output logic [NUM_CH*12-1:0]  raw_val,
  output logic                  busy,
  output logic                  sweep_done,
  output logic                  timeout_err,
  output logic [2:0]            dbg_state
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_DONE} state_t;

  localparam logic [1:0]  C_CENTRE = 2'd0;
  localparam logic [1:0]  C_LOW    = 2'd1;
  localparam logic [1:0]  C_HIGH   = 2'd2;
  // Hysteresis exit points, 13 bits so the sum cannot wrap.
  localparam logic [12:0] LO_EXIT  = {1'b0, LOW_TH} + {1'b0, HYST};
  localparam logic [12:0] HI_EXIT  = {1'b0, HIGH_TH} - {1'b0, HYST};

  state_t      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [11:0] sample_q, sample_d;
  logic [11:0] raw_q  [NUM_CH];
  logic [1:0]  cls_q  [NUM_CH];
  logic [1:0]  pend_q [NUM_CH];
  logic [3:0]  cnt_q  [NUM_CH];
  logic        last_ch, timeout_hit;
  logic [1:0]  cur_cls, cur_pend, from_centre, cand, cls_d, pend_d;
  logic [3:0]  cur_cnt, run, cnt_d;
  logic [6:0]  daddr;
  logic [3:0]  unused_do_lsb;

  assign unused_do_lsb = drp.drp_do[3:0];
  assign last_ch       = (ch_q == 3'(NUM_CH - 1));

  // State, channel index and captured sample registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      sample_q <= sample_d;
    end
  end

  // Sweep sequencing: IDLE -> (REQ -> WAIT -> EVAL) per channel -> DONE.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    sample_d = sample_q;
    case (state_q)
      S_IDLE: if (sample_req) begin
        state_d = S_REQ;
        ch_d    = '0;
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (drp.drp_drdy) begin
          sample_d = drp.drp_do[15:4];
          state_d  = S_EVAL;
        end else if (timeout_hit) begin
          state_d = last_ch ? S_DONE : S_REQ;
          ch_d    = last_ch ? ch_q : ch_q + 3'd1;
        end
      end
      S_EVAL: begin
        state_d = last_ch ? S_DONE : S_REQ;
        ch_d    = last_ch ? ch_q : ch_q + 3'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef JOYSCAN_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic        to_err_q;

  assign timeout_hit = (wait_cnt_q == 16'(TIMEOUT - 1));
  assign timeout_err = to_err_q;

  // Count cycles spent in WAIT; latch the error when drdy never came.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      to_err_q   <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 16'd1 : '0;
      if (state_q == S_WAIT && !drp.drp_drdy && timeout_hit) to_err_q <= 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // Select the state of the channel currently being swept.
  always_comb begin
    cur_cls  = C_CENTRE;
    cur_pend = C_CENTRE;
    cur_cnt  = '0;
    daddr    = CH_ADDR[6:0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == 3'(i)) begin
        cur_cls  = cls_q[i];
        cur_pend = pend_q[i];
        cur_cnt  = cnt_q[i];
        daddr    = CH_ADDR[i*7 +: 7];
      end
    end
  end

  // Candidate class with hysteresis, then the consecutive-agreement filter.
  always_comb begin
    from_centre = (sample_q < LOW_TH)  ? C_LOW  :
                  (sample_q > HIGH_TH) ? C_HIGH : C_CENTRE;
    case (cur_cls)
      C_LOW:   cand = ({1'b0, sample_q} < LO_EXIT) ? C_LOW  : from_centre;
      C_HIGH:  cand = ({1'b0, sample_q} > HI_EXIT) ? C_HIGH : from_centre;
      default: cand = from_centre;
    endcase
    // A run continues only while the same differing candidate repeats.
    run    = (cur_cnt != 4'd0 && cand == cur_pend) ?
             ((cur_cnt == 4'hF) ? 4'hF : cur_cnt + 4'd1) : 4'd1;
    cls_d  = cur_cls;
    pend_d = cur_pend;
    cnt_d  = cur_cnt;
    if (cand == cur_cls) begin
      cnt_d = '0;
    end else if (run >= 4'(FILT_CNT)) begin
      cls_d = cand;
      cnt_d = '0;
    end else begin
      cnt_d  = run;
      pend_d = cand;
    end
  end

  // Per-channel sample, class and filter registers, written in EVAL.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        raw_q[i]  <= '0;
        cls_q[i]  <= C_CENTRE;
        pend_q[i] <= C_CENTRE;
        cnt_q[i]  <= '0;
      end
    end else if (state_q == S_EVAL) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_q == 3'(i)) begin
          raw_q[i]  <= sample_q;
          cls_q[i]  <= cls_d;
          pend_q[i] <= pend_d;
          cnt_q[i]  <= cnt_d;
        end
      end
    end
  end

  // Flatten per-channel state onto the output buses.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      dir_lo[i]           = (cls_q[i] == C_LOW);
      dir_hi[i]           = (cls_q[i] == C_HIGH);
      raw_val[i*12 +: 12] = raw_q[i];
    end
  end

  assign drp.drp_den   = (state_q == S_REQ);
  assign drp.drp_daddr = daddr;
  assign busy          = (state_q != S_IDLE);
  assign sweep_done    = (state_q == S_DONE);
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_joystick_scanner.sv
// Bench for joystick_scanner: an XADC DRP responder with programmable drdy
// delay, a behavioural classifier/filter model, directed scenarios and a
// randomized sweep phase.
module tb_joystick_scanner;
  localparam int NUM_CH   = 4;
  localparam int TIMEOUT  = 10;
  localparam int LOW_TH   = 'h400;
  localparam int HIGH_TH  = 'hC00;
  localparam int HYST     = 'h080;
  localparam int FILT_CNT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic sample_req;
  always #5 clk = ~clk;

  joystick_scanner_if drp_if();
  logic [NUM_CH-1:0]    dir_lo, dir_hi;
  logic [NUM_CH*12-1:0] raw_val;
  logic                 busy, sweep_done, timeout_err;
  logic [2:0]           dbg_state;

  joystick_scanner #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .sample_req(sample_req), .drp(drp_if.master),
    .dir_lo(dir_lo), .dir_hi(dir_hi), .raw_val(raw_val), .busy(busy),
    .sweep_done(sweep_done), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  int          total = 0;
  int          bad   = 0;
  int          exp_addr [NUM_CH] = '{'h16, 'h17, 'h1E, 'h1F};
  logic [11:0] smp      [NUM_CH];
  bit          withhold [NUM_CH];
  int          drdy_dly;
  logic [6:0]  addr_q [$];
  int          den_cnt = 0, done_cnt = 0, both_err = 0, den2_err = 0;
  bit          prev_den = 1'b0;

  // behavioural model: 0 centre, 1 low, 2 high
  int          m_cls [NUM_CH];
  int          m_pend[NUM_CH];
  int          m_run [NUM_CH];
  logic [11:0] m_raw [NUM_CH];
  bit          m_to;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int classify(input int s, input int c);
    int fc;
    fc = (s < LOW_TH) ? 1 : (s > HIGH_TH) ? 2 : 0;
    if (c == 1 && s < LOW_TH + HYST)  return 1;
    if (c == 2 && s > HIGH_TH - HYST) return 2;
    return fc;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cls[i] = 0; m_pend[i] = 0; m_run[i] = 0; m_raw[i] = '0;
    end
    m_to = 1'b0;
  endtask

  task automatic model_sample(input int ch, input logic [11:0] s);
    int cand;
    m_raw[ch] = s;
    cand = classify(int'(s), m_cls[ch]);
    if (cand == m_cls[ch]) m_run[ch] = 0;
    else begin
      if (m_run[ch] > 0 && cand == m_pend[ch]) m_run[ch]++;
      else begin m_run[ch] = 1; m_pend[ch] = cand; end
      if (m_run[ch] >= FILT_CNT) begin m_cls[ch] = cand; m_run[ch] = 0; end
    end
  endtask

  task automatic model_sweep();
    for (int i = 0; i < NUM_CH; i++) begin
      if (withhold[i]) m_to = 1'b1;
      else model_sample(i, smp[i]);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_CH-1:0]    el, eh;
    logic [NUM_CH*12-1:0] er;
    for (int i = 0; i < NUM_CH; i++) begin
      el[i] = (m_cls[i] == 1);
      eh[i] = (m_cls[i] == 2);
      er[i*12 +: 12] = m_raw[i];
    end
    chk({tag, "_dir_lo"}, dir_lo, el);
    chk({tag, "_dir_hi"}, dir_hi, eh);
    chk({tag, "_raw"}, raw_val, er);
    chk({tag, "_tmo"}, timeout_err, m_to);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // ---------------- XADC responder ----------------
  initial begin
    drp_if.drp_drdy = 1'b0;
    drp_if.drp_do   = '0;
    forever begin
      @(negedge clk);
      if (drp_if.drp_den) begin : serve
        int ch;
        ch = -1;
        for (int i = 0; i < NUM_CH; i++)
          if (drp_if.drp_daddr == 7'(exp_addr[i])) ch = i;
        addr_q.push_back(drp_if.drp_daddr);
        if (ch >= 0 && !withhold[ch]) begin
          repeat (drdy_dly) @(negedge clk);
          drp_if.drp_do   = {smp[ch], 4'($urandom_range(0, 15))};
          drp_if.drp_drdy = 1'b1;
          @(negedge clk);
          drp_if.drp_drdy = 1'b0;
          drp_if.drp_do   = 16'($urandom);
        end
      end
    end
  end

  // ---------------- passive monitor ----------------
  always @(negedge clk) begin
    if (drp_if.drp_den) den_cnt++;
    if (sweep_done) done_cnt++;
    if (|(dir_lo & dir_hi)) both_err++;
    if (drp_if.drp_den && prev_den) den2_err++;
    prev_den = drp_if.drp_den;
  end

  // ---------------- driver tasks ----------------
  task automatic run_sweep(input string tag);
    int cyc, d0, exp_len;
    d0 = done_cnt;
    addr_q.delete();
    exp_len = 1;
    for (int i = 0; i < NUM_CH; i++) exp_len += withhold[i] ? (1 + TIMEOUT) : (drdy_dly + 2);
    @(negedge clk); sample_req = 1'b1;
    @(negedge clk); sample_req = 1'b0;
    chk({tag, "_den_lat"}, drp_if.drp_den, 1'b1);
    chk({tag, "_busy_on"}, busy, 1'b1);
    cyc = 1;
    while (!sweep_done && cyc < 400) begin @(negedge clk); cyc++; end
    chk({tag, "_len"}, cyc, exp_len);
    @(negedge clk);
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_naddr"}, addr_q.size(), NUM_CH);
    for (int i = 0; i < NUM_CH && i < addr_q.size(); i++)
      chk({tag, "_addr"}, addr_q[i], exp_addr[i]);
    model_sweep();
    check_outputs(tag);
  endtask

  function automatic logic [11:0] pick(input logic [11:0] prev);
    case ($urandom_range(0, 11))
      0: return 12'h3FF;  1: return 12'h400;  2: return 12'h47F;
      3: return 12'h480;  4: return 12'hB80;  5: return 12'hB81;
      6: return 12'hC00;  7: return 12'hC01;  8: return 12'h000;
      9: return 12'hFFF;  10: return prev;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int cyc, d0, n0;
    reset = 1'b0; sample_req = 1'b0; drdy_dly = 3;
    for (int i = 0; i < NUM_CH; i++) begin smp[i] = 12'h800; withhold[i] = 1'b0; end
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", sweep_done, 1'b0);
    chk("rst_den", drp_if.drp_den, 1'b0);
    chk("rst_daddr", drp_if.drp_daddr, 7'h16);
    chk("rst_lo", dir_lo, '0);
    chk("rst_hi", dir_hi, '0);
    chk("rst_raw", raw_val, '0);
    chk("rst_tmo", timeout_err, 1'b0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_den_cnt", den_cnt, 0);
    chk("idle_busy", busy, 1'b0);

    // single centred sweep
    run_sweep("s800");
    chk("s800_raw_const", raw_val, {4{12'h800}});

    // filter on channel 0
    smp[0] = 12'h100; run_sweep("filt1"); chk("filt1_lo0", dir_lo[0], 1'b0);
    run_sweep("filt2"); chk("filt2_lo0", dir_lo[0], 1'b1);
    smp[0] = 12'h900; run_sweep("filt3"); chk("filt3_lo0", dir_lo[0], 1'b1);
    run_sweep("filt4"); chk("filt4_lo0", dir_lo[0], 1'b0);

    // hysteresis on channel 2
    smp[2] = 12'hFFF; run_sweep("hys0"); run_sweep("hys1"); chk("hys1_hi2", dir_hi[2], 1'b1);
    smp[2] = 12'hB90; run_sweep("hys2"); chk("hys2_hi2", dir_hi[2], 1'b1);
    smp[2] = 12'hB80; run_sweep("hys3"); chk("hys3_hi2", dir_hi[2], 1'b1);
    run_sweep("hys4"); chk("hys4_hi2", dir_hi[2], 1'b0);
    smp[2] = 12'hC00; run_sweep("hys5"); run_sweep("hys6"); chk("hys6_hi2", dir_hi[2], 1'b0);

    // sample_req while busy is dropped
    d0 = done_cnt; n0 = den_cnt;
    @(negedge clk); sample_req = 1'b1;
    @(negedge clk); sample_req = 1'b0;
    cyc = 0;
    while (den_cnt - n0 < 2 && cyc < 200) begin @(negedge clk); cyc++; end
    sample_req = 1'b1;
    @(negedge clk); sample_req = 1'b0;
    cyc = 0;
    while (!sweep_done && cyc < 400) begin @(negedge clk); cyc++; end
    chk("midreq_timeout", cyc < 400, 1'b1);
    repeat (40) @(negedge clk);
    chk("midreq_done", done_cnt - d0, 1);
    chk("midreq_den", den_cnt - n0, NUM_CH);
    model_sweep();
    check_outputs("midreq");

    // reset during WAIT; the late drdy must be ignored
    smp[1] = 12'h050;
    @(negedge clk); sample_req = 1'b1;
    @(negedge clk); sample_req = 1'b0;
    cyc = 0;
    while (!(drp_if.drp_den && drp_if.drp_daddr == 7'h17) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    chk("rstw_found_ch1", cyc < 200, 1'b1);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_den", drp_if.drp_den, 1'b0);
    reset = 1'b1;
    n0 = den_cnt; d0 = done_cnt;
    repeat (12) @(negedge clk);
    chk("rstw_no_den", den_cnt - n0, 0);
    chk("rstw_no_done", done_cnt - d0, 0);
    model_reset();
    check_outputs("rstw");
    run_sweep("recover");

    // randomized sweeps with spurious idle drdy pulses
    for (int k = 0; k < 24; k++) begin
      drdy_dly = $urandom_range(1, 5);
      for (int i = 0; i < NUM_CH; i++) smp[i] = pick(smp[i]);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        drp_if.drp_do   = 16'($urandom);
        drp_if.drp_drdy = 1'b1;
        @(negedge clk);
        drp_if.drp_drdy = 1'b0;
      end
      run_sweep($sformatf("rnd%0d", k));
    end

`ifdef JOYSCAN_TIMEOUT_EN
    // drdy withheld on channel 1: timeout, channel 1 untouched, sweep completes
    drdy_dly = 3;
    smp[1] = 12'hABC;
    withhold[1] = 1'b1;
    run_sweep("tmo");
    chk("tmo_err", timeout_err, 1'b1);
    withhold[1] = 1'b0;
`endif

    chk("never_both", both_err, 0);
    chk("den_single", den2_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/joystick_scanner.md
Name: joystick_scanner

Overview:
- Parametrised successor to the top-level vsync-toggled joystick polling: sweeps NUM_CH XADC auxiliary channels over the DRP port using a proper den/drdy handshake.
- Classifies each 12-bit sample into low/centre/high with hysteresis and a consecutive-sample filter.
- Drives per-channel direction flags into gameLogic (moveup/movedown/moveleft/moveright per player).
- Sits between xadc_wiz_0 and gameLogic; a vsync-derived single-cycle pulse triggers each sweep.

Parameters:
- NUM_CH, 4, number of analog channels swept per request (1..8)
- CH_ADDR, {7'h1F,7'h1E,7'h17,7'h16}, packed NUM_CH*7 DRP addresses; channel i = bits [7i+6:7i]
- LOW_TH, 12'h400, sample strictly below this enters LOW
- HIGH_TH, 12'hC00, sample strictly above this enters HIGH
- HYST, 12'h080, hysteresis band for leaving LOW/HIGH
- FILT_CNT, 2, consecutive agreeing samples required to change a direction flag (1..15)
- TIMEOUT, 255, cycles to wait for drdy (only with JOYSCAN_TIMEOUT_EN)

Ports:
- clk  in  1  system clock (same clk as xadc dclk_in)
- reset  in  1  synchronous, active-low reset
- sample_req  in  1  one-cycle pulse: start a sweep
- drp_daddr  out  7  DRP address
- drp_den  out  1  DRP enable, one-cycle pulse per read
- drp_do  in  16  DRP read data; sample = drp_do[15:4]
- drp_drdy  in  1  DRP data valid
- dir_lo  out  NUM_CH  channel i filtered LOW (up / left)
- dir_hi  out  NUM_CH  channel i filtered HIGH (down / right)
- raw_val  out  NUM_CH*12  last captured sample per channel
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at end of sweep
- timeout_err  out  1  sticky drdy timeout flag

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs 0, drp_daddr = CH_ADDR[0].
  - FSM to IDLE; per-channel class = CENTRE; filter counters 0.
  - Applies mid-sweep too: den drops the same edge and any pending drdy is ignored.
- FSM states:
  - IDLE: busy=0. sample_req=1 -> REQ with ch=0.
  - REQ: drp_den=1 for exactly one cycle, drp_daddr=CH_ADDR[ch] (held through WAIT) -> WAIT.
  - WAIT: on drp_drdy=1 capture drp_do[15:4] -> EVAL.
  - EVAL: update raw_val[ch], the class and the filter. If ch==NUM_CH-1 -> DONE, else ch+1 -> REQ.
  - DONE: sweep_done=1 for one cycle -> IDLE.
- Latency: sample_req at cycle 0 -> den at cycle 1. drdy at cycle t -> raw_val/dir updated and visible at t+2.
- sample_req while busy is ignored; no queuing. drdy outside WAIT is ignored.
- Class candidate from sample s and current class c:
  - c=LOW: stays LOW while s < LOW_TH+HYST; else re-evaluate as from CENTRE.
  - c=HIGH: stays HIGH while s > HIGH_TH-HYST; else re-evaluate as from CENTRE.
  - From CENTRE: s<LOW_TH -> LOW; s>HIGH_TH -> HIGH; else CENTRE. Equality with a threshold is CENTRE.
  - Threshold+HYST arithmetic uses 13 bits, so there is no wrap.
- Filter (per channel):
  - Candidate == current output class: counter cleared.
  - Otherwise counter increments (saturating). On reaching FILT_CNT the output class takes the candidate and the counter clears.
  - A differing but different candidate (e.g. LOW then HIGH) restarts the counter at 1.
  - FILT_CNT=1 updates on every sample.
- dir_lo[i]=(class==LOW), dir_hi[i]=(class==HIGH); never both 1.
- timeout_err clears only on reset.

Optional Feature:
- JOYSCAN_TIMEOUT_EN defined:
  - WAIT counts cycles. If it reaches TIMEOUT without drdy: timeout_err=1, raw_val/class/filter of that channel unchanged, and the FSM advances as from EVAL.
- Undefined: WAIT waits indefinitely and timeout_err is tied 0.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 -> all outputs 0, drp_den never asserts without sample_req.
- Single sweep, model drdy 3 cycles after each den, all samples 12'h800:
  - den pulses at addresses 16,17,1E,1F in order.
  - sweep_done pulses once; dir_lo=dir_hi=0; raw_val = 4 x 12'h800.
- Filter, FILT_CNT=2, channel 0:
  - Sample 12'h100 on sweep 1 -> dir_lo[0]=0.
  - Sample 12'h100 on sweep 2 -> dir_lo[0]=1.
  - Sample 12'h900 on sweep 3 -> dir_lo[0] still 1.
- Hysteresis, channel 2 in HIGH:
  - Sample 12'hB90 (> C00-080) -> stays HIGH.
  - Sample 12'hB80 twice -> returns to CENTRE.
  - Sample 12'hC00 exactly -> CENTRE candidate.
- sample_req asserted mid-sweep and reset=0 asserted during WAIT:
  - Extra request ignored (one sweep_done only).
  - Reset drops den/busy the next edge and a late drdy is ignored.
- JOYSCAN_TIMEOUT_EN, TIMEOUT=10, drdy withheld for channel 1:
  - timeout_err=1 at 10 cycles.
  - Channel 1 raw_val unchanged; channels 2,3 still read; sweep_done pulses.
